// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline boundary: forward-select codes,
// the link register number and the ALU operation code width.
package pipe_pkg;

  // Operand source selected by the control unit's dependency codes
  localparam logic [1:0] FWD_RF  = 2'b00;  // register-file read data
  localparam logic [1:0] FWD_EXE = 2'b01;  // ALU result currently in EX
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result currently in MEM
  localparam logic [1:0] FWD_MMO = 2'b11;  // load data currently in MEM

  // jal writes its return address here
  localparam logic [4:0] REG_RA = 5'd31;

  // Width of the ALU operation code
  localparam int ALUC_W = 5;

endpackage

// File: rtl/pipe_fwd_mux.sv
// 4:1 operand selector driven by a forward-select code.
module pipe_fwd_mux
  import pipe_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    sel,
  input  logic [DW-1:0] rf,
  input  logic [DW-1:0] exe,
  input  logic [DW-1:0] mem,
  input  logic [DW-1:0] mmo,
  output logic [DW-1:0] y
);

  // Pick the freshest copy of the operand named by sel
  always_comb begin
    y = rf;
    case (sel)
      FWD_RF:  y = rf;
      FWD_EXE: y = exe;
      FWD_MEM: y = mem;
      FWD_MMO: y = mmo;
      default: y = rf;
    endcase
  end

endmodule

// File: rtl/pipe_idex_stage.sv
// ID/EX pipeline register. Resolves forwarded operands, latches decoded
// controls into EX, and loads a bubble on a load-use hazard or an EX flush.
// The stage never holds: every edge loads either the ID instruction or a
// bubble. A bubble clears ewreg and ern so it never looks like a producer
// to the control unit's hazard logic.
// Optional build macro PIPE_STALL_CNT_EN adds saturating stall_cnt and
// flush_cnt event counters.
module pipe_idex_stage
  import pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wreg,
  input  logic              m2reg,
  input  logic              wmem,
  input  logic              regrt,
  input  logic              sext,
  input  logic              jal,
  input  logic              j,
  input  logic              beq,
  input  logic              bne,
  input  logic [ALUC_W-1:0] aluc,
  input  logic              load_depen,
  input  logic [1:0]        a_depen,
  input  logic [1:0]        b_depen,
  input  logic [1:0]        store_depen,
  input  logic              flush,
  input  logic [DW-1:0]     qa,
  input  logic [DW-1:0]     qb,
  input  logic [DW-1:0]     ealu,
  input  logic [DW-1:0]     malu,
  input  logic [DW-1:0]     mmo,
  input  logic [DW-1:0]     imm,
  input  logic [DW-1:0]     pc4,
  input  logic [RW-1:0]     rd,
  input  logic [RW-1:0]     rt,
  output logic              stall_n,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic              ejal,
  output logic              ealuimm,
  output logic [ALUC_W-1:0] ealuc,
  output logic [RW-1:0]     ern,
  output logic [DW-1:0]     ea,
  output logic [DW-1:0]     eb,
  output logic [DW-1:0]     estore,
  output logic [DW-1:0]     eimm,
  output logic [DW-1:0]     epc4,
  output logic              ex_is_uncond,
  output logic              ex_is_cond,
`ifdef PIPE_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic              evalid
);

  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;
  logic [DW-1:0] fwd_s;
  logic          bubble;
  logic          aluimm_id;
  logic [RW-1:0] rn_id;

  // The immediate is already extended upstream, so sext has no use here
  logic unused_sext;
  assign unused_sext = sext;

  pipe_fwd_mux #(.DW(DW)) u_fwd_a (
    .sel(a_depen), .rf(qa), .exe(ealu), .mem(malu), .mmo(mmo), .y(fwd_a)
  );

  pipe_fwd_mux #(.DW(DW)) u_fwd_b (
    .sel(b_depen), .rf(qb), .exe(ealu), .mem(malu), .mmo(mmo), .y(fwd_b)
  );

  // Store data has its own select so sw can use the immediate on B while
  // still forwarding the value being stored
  pipe_fwd_mux #(.DW(DW)) u_fwd_s (
    .sel(store_depen), .rf(qb), .exe(ealu), .mem(malu), .mmo(mmo), .y(fwd_s)
  );

  // Flush kills the ID instruction, so a concurrent load-use hazard is moot
  // and must not freeze the front end; reset also releases the stall
  always_comb begin
    bubble    = load_depen | flush;
    stall_n   = ~(load_depen & ~flush) | ~resetn;
    aluimm_id = regrt & ~jal;
    rn_id     = rd;
    if (jal)        rn_id = RW'(REG_RA);
    else if (regrt) rn_id = rt;
  end

  // ID/EX register: load the instruction or an all-zero bubble every edge
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ewreg        <= 1'b0;
      em2reg       <= 1'b0;
      ewmem        <= 1'b0;
      ejal         <= 1'b0;
      ealuimm      <= 1'b0;
      ealuc        <= '0;
      ern          <= '0;
      ea           <= '0;
      eb           <= '0;
      estore       <= '0;
      eimm         <= '0;
      epc4         <= '0;
      ex_is_uncond <= 1'b0;
      ex_is_cond   <= 1'b0;
      evalid       <= 1'b0;
    end else if (bubble) begin
      ewreg        <= 1'b0;
      em2reg       <= 1'b0;
      ewmem        <= 1'b0;
      ejal         <= 1'b0;
      ealuimm      <= 1'b0;
      ealuc        <= '0;
      ern          <= '0;
      ea           <= '0;
      eb           <= '0;
      estore       <= '0;
      eimm         <= '0;
      epc4         <= '0;
      ex_is_uncond <= 1'b0;
      ex_is_cond   <= 1'b0;
      evalid       <= 1'b0;
    end else begin
      ewreg        <= wreg;
      em2reg       <= m2reg;
      ewmem        <= wmem;
      ejal         <= jal;
      ealuimm      <= aluimm_id;
      ealuc        <= aluc;
      ern          <= rn_id;
      ea           <= fwd_a;
      eb           <= aluimm_id ? imm : fwd_b;
      estore       <= fwd_s;
      eimm         <= imm;
      epc4         <= pc4;
      ex_is_uncond <= j | jal;
      ex_is_cond   <= beq | bne;
      evalid       <= 1'b1;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  // Saturating counts of load-use stall edges and flush edges
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (load_depen && !flush && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_idex_stage.sv
// Directed, table-driven bench for pipe_idex_stage.
module tb_pipe_idex_stage;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  localparam logic [DW-1:0] QA   = 32'h1000_0001;
  localparam logic [DW-1:0] QB   = 32'h0000_0001;
  localparam logic [DW-1:0] EALU = 32'h0000_00AA;
  localparam logic [DW-1:0] MALU = 32'h0000_0055;
  localparam logic [DW-1:0] MMO  = 32'h0000_1234;
  localparam logic [DW-1:0] IMM  = 32'h0000_0010;
  localparam logic [DW-1:0] PC4  = 32'h0000_0040;
  localparam logic [RW-1:0] RD   = 5'd3;
  localparam logic [RW-1:0] RT   = 5'd7;
  localparam logic [4:0]    ALUC = 5'h0A;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic wreg, m2reg, wmem, regrt, sext, jal, j, beq, bne;
  logic [4:0] aluc;
  logic load_depen, flush;
  logic [1:0] a_depen, b_depen, store_depen;
  logic [DW-1:0] qa, qb, ealu, malu, mmo, imm, pc4;
  logic [RW-1:0] rd, rt;

  logic stall_n, ewreg, em2reg, ewmem, ejal, ealuimm;
  logic [4:0] ealuc;
  logic [RW-1:0] ern;
  logic [DW-1:0] ea, eb, estore, eimm, epc4;
  logic ex_is_uncond, ex_is_cond, evalid;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_idex_stage #(.DW(DW), .RW(RW)) dut (
    .clock(clock), .resetn(resetn),
    .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .regrt(regrt), .sext(sext),
    .jal(jal), .j(j), .beq(beq), .bne(bne), .aluc(aluc),
    .load_depen(load_depen), .a_depen(a_depen), .b_depen(b_depen),
    .store_depen(store_depen), .flush(flush),
    .qa(qa), .qb(qb), .ealu(ealu), .malu(malu), .mmo(mmo), .imm(imm),
    .pc4(pc4), .rd(rd), .rt(rt),
    .stall_n(stall_n), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ejal(ejal), .ealuimm(ealuimm), .ealuc(ealuc), .ern(ern),
    .ea(ea), .eb(eb), .estore(estore), .eimm(eimm), .epc4(epc4),
    .ex_is_uncond(ex_is_uncond), .ex_is_cond(ex_is_cond),
`ifdef PIPE_STALL_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .evalid(evalid)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string name;
    logic wreg, m2reg, wmem, regrt, jal, j, beq, bne, ld, fl;
    logic [1:0] ad, bd, sd;
    logic x_stall_n, x_ewreg, x_em2reg, x_ewmem, x_ejal, x_ealuimm;
    logic x_unc, x_cond, x_valid;
    logic [RW-1:0] x_ern;
    logic [DW-1:0] x_ea, x_eb, x_es;
  } vec_t;

  vec_t vecs[12];

  // ---------------- driver tasks ----------------
  task automatic drive_common();
    sext = T; aluc = ALUC;
    qa = QA; qb = QB; ealu = EALU; malu = MALU; mmo = MMO;
    imm = IMM; pc4 = PC4; rd = RD; rt = RT;
  endtask

  task automatic drive_vec(input vec_t v);
    wreg = v.wreg; m2reg = v.m2reg; wmem = v.wmem; regrt = v.regrt;
    jal = v.jal; j = v.j; beq = v.beq; bne = v.bne;
    load_depen = v.ld; flush = v.fl;
    a_depen = v.ad; b_depen = v.bd; store_depen = v.sd;
  endtask

  task automatic drive_idle();
    wreg = F; m2reg = F; wmem = F; regrt = F; jal = F; j = F; beq = F; bne = F;
    load_depen = F; flush = F; a_depen = FWD_RF; b_depen = FWD_RF;
    store_depen = FWD_RF;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ewreg"}, DW'(ewreg), '0);
    check({tag, ".em2reg"}, DW'(em2reg), '0);
    check({tag, ".ewmem"}, DW'(ewmem), '0);
    check({tag, ".ejal"}, DW'(ejal), '0);
    check({tag, ".ealuimm"}, DW'(ealuimm), '0);
    check({tag, ".ealuc"}, DW'(ealuc), '0);
    check({tag, ".ern"}, DW'(ern), '0);
    check({tag, ".ea"}, ea, '0);
    check({tag, ".eb"}, eb, '0);
    check({tag, ".estore"}, estore, '0);
    check({tag, ".eimm"}, eimm, '0);
    check({tag, ".epc4"}, epc4, '0);
    check({tag, ".ex_is_uncond"}, DW'(ex_is_uncond), '0);
    check({tag, ".ex_is_cond"}, DW'(ex_is_cond), '0);
    check({tag, ".evalid"}, DW'(evalid), '0);
  endtask

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] s0, f0;
`endif

  initial begin
    //             name  wreg m2r wmem rgrt jal j beq bne ld fl  ad bd sd
    //             stall ewreg em2r ewmem ejal aimm unc cond valid ern ea eb es
    vecs[0]  = '{"sw_fwd_exe", F,F,T,T,F,F,F,F,F,F, FWD_RF,FWD_RF,FWD_EXE,
                 T,F,F,T,F,T,F,F,T, RT, QA, IMM, EALU};
    vecs[1]  = '{"sw_fwd_mem", F,F,T,T,F,F,F,F,F,F, FWD_RF,FWD_RF,FWD_MEM,
                 T,F,F,T,F,T,F,F,T, RT, QA, IMM, MALU};
    vecs[2]  = '{"add_fwd", T,F,F,F,F,F,F,F,F,F, FWD_EXE,FWD_MEM,FWD_RF,
                 T,T,F,F,F,F,F,F,T, RD, EALU, MALU, QB};
    vecs[3]  = '{"load_use", T,F,F,F,F,F,F,F,T,F, FWD_RF,FWD_RF,FWD_RF,
                 F,F,F,F,F,F,F,F,F, 5'd0, 32'd0, 32'd0, 32'd0};
    vecs[4]  = '{"after_stall_mmo", T,F,F,F,F,F,F,F,F,F, FWD_MMO,FWD_MMO,FWD_RF,
                 T,T,F,F,F,F,F,F,T, RD, MMO, MMO, QB};
    vecs[5]  = '{"flush_and_load", T,T,F,F,F,F,F,F,T,T, FWD_RF,FWD_RF,FWD_RF,
                 T,F,F,F,F,F,F,F,F, 5'd0, 32'd0, 32'd0, 32'd0};
    vecs[6]  = '{"jal", T,F,F,T,T,F,F,F,F,F, FWD_RF,FWD_RF,FWD_RF,
                 T,T,F,F,T,F,T,F,T, REG_RA, QA, QB, QB};
    vecs[7]  = '{"bne", F,F,F,F,F,F,F,T,F,F, FWD_RF,FWD_RF,FWD_RF,
                 T,F,F,F,F,F,F,T,T, RD, QA, QB, QB};
    vecs[8]  = '{"lw", T,T,F,T,F,F,F,F,F,F, FWD_RF,FWD_RF,FWD_RF,
                 T,T,T,F,F,T,F,F,T, RT, QA, IMM, QB};
    vecs[9]  = '{"j", F,F,F,F,F,T,F,F,F,F, FWD_RF,FWD_RF,FWD_RF,
                 T,F,F,F,F,F,T,F,T, RD, QA, QB, QB};
    vecs[10] = '{"flush_only", T,F,T,F,F,F,F,F,F,T, FWD_RF,FWD_RF,FWD_RF,
                 T,F,F,F,F,F,F,F,F, 5'd0, 32'd0, 32'd0, 32'd0};
    vecs[11] = '{"beq_mem", F,F,F,F,F,F,T,F,F,F, FWD_MEM,FWD_RF,FWD_MMO,
                 T,F,F,F,F,F,F,T,T, RD, MALU, QB, MMO};

    // ---------- reset with toggling inputs ----------
    drive_common();
    drive_idle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      wreg = 1'($urandom_range(0, 1)); jal = 1'($urandom_range(0, 1));
      load_depen = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
      a_depen = 2'($urandom_range(0, 3)); qa = $urandom;
      #1 check("reset.stall_n", DW'(stall_n), 32'd1);
    end
    check_all_zero("reset");
    drive_common();
    drive_idle();
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;
    check("first_edge.evalid", DW'(evalid), 32'd1);

    // ---------- table ----------
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      drive_vec(vecs[i]);
      #1 check({vecs[i].name, ".stall_n"}, DW'(stall_n), DW'(vecs[i].x_stall_n));
      @(posedge clock); #1;
      check({vecs[i].name, ".ewreg"}, DW'(ewreg), DW'(vecs[i].x_ewreg));
      check({vecs[i].name, ".em2reg"}, DW'(em2reg), DW'(vecs[i].x_em2reg));
      check({vecs[i].name, ".ewmem"}, DW'(ewmem), DW'(vecs[i].x_ewmem));
      check({vecs[i].name, ".ejal"}, DW'(ejal), DW'(vecs[i].x_ejal));
      check({vecs[i].name, ".ealuimm"}, DW'(ealuimm), DW'(vecs[i].x_ealuimm));
      check({vecs[i].name, ".ex_is_uncond"}, DW'(ex_is_uncond), DW'(vecs[i].x_unc));
      check({vecs[i].name, ".ex_is_cond"}, DW'(ex_is_cond), DW'(vecs[i].x_cond));
      check({vecs[i].name, ".evalid"}, DW'(evalid), DW'(vecs[i].x_valid));
      check({vecs[i].name, ".ern"}, DW'(ern), DW'(vecs[i].x_ern));
      check({vecs[i].name, ".ea"}, ea, vecs[i].x_ea);
      check({vecs[i].name, ".eb"}, eb, vecs[i].x_eb);
      check({vecs[i].name, ".estore"}, estore, vecs[i].x_es);
      check({vecs[i].name, ".ealuc"}, DW'(ealuc), vecs[i].x_valid ? DW'(ALUC) : '0);
      check({vecs[i].name, ".eimm"}, eimm, vecs[i].x_valid ? IMM : '0);
      check({vecs[i].name, ".epc4"}, epc4, vecs[i].x_valid ? PC4 : '0);
    end

`ifdef PIPE_STALL_CNT_EN
    // ---------- event counters ----------
    // So far: one load-only edge (load_use), flush edges at flush_and_load and flush_only
    check("cnt.stall", stall_cnt, 32'd1);
    check("cnt.flush", flush_cnt, 32'd2);
    s0 = stall_cnt; f0 = flush_cnt;
    @(negedge clock);
    drive_idle(); flush = T; load_depen = T;
    @(posedge clock); #1;
    check("cnt.flush_load.flush", flush_cnt, f0 + 32'd1);
    check("cnt.flush_load.stall", stall_cnt, s0);
    @(negedge clock);
    drive_idle(); load_depen = T;
    @(posedge clock); #1;
    check("cnt.load.stall", stall_cnt, s0 + 32'd1);
    check("cnt.load.flush", flush_cnt, f0 + 32'd1);
`endif

    // ---------- reset asserted mid-stall ----------
    @(negedge clock);
    drive_idle(); wreg = T;
    @(posedge clock); #1;
    check("pre_midrst.evalid", DW'(evalid), 32'd1);
    @(negedge clock);
    load_depen = T;
    #1 check("midrst.stall_n_before", DW'(stall_n), 32'd0);
    #1 resetn = 1'b0;
    #1 check("midrst.stall_n", DW'(stall_n), 32'd1);
    check_all_zero("midrst");
`ifdef PIPE_STALL_CNT_EN
    check("midrst.stall_cnt", stall_cnt, 32'd0);
    check("midrst.flush_cnt", flush_cnt, 32'd0);
`endif
    @(negedge clock);
    drive_idle();
    resetn = 1'b1;
    @(posedge clock); #1;
    check("post_midrst.evalid", DW'(evalid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_idex_stage.md
Name: pipe_idex_stage

Overview:
- ID/EX pipeline boundary register; the consumer side of the ID control unit's hazard and forwarding outputs.
- Selects forwarded operands using the a/b/store dependency codes and latches decoded controls into the EX stage.
- Inserts bubbles on load-use hazards and on EX-resolved branch or jump flushes.
- Feeds ewreg/em2reg/ern/ex_is_uncond/ex_is_cond back to the control unit for the next instruction's hazard checks.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-number width.

Ports:
- clock  in  1  stage clock, rising edge.
- resetn  in  1  asynchronous reset, active low.
- wreg, m2reg, wmem, regrt, sext, jal, j, beq, bne  in  1 each  decoded ID controls.
- aluc  in  5  ALU operation code.
- load_depen  in  1  1 = load-use hazard on the ID instruction.
- a_depen, b_depen, store_depen  in  2 each  forward select: 00 regfile, 01 EX alu result, 10 MEM alu result, 11 MEM load data.
- flush  in  1  taken branch/jump resolved in EX; kill the ID instruction.
- qa, qb  in  DW  register-file read data.
- ealu, malu, mmo  in  DW  EX result, MEM result, MEM load data.
- imm  in  DW  extended immediate.
- pc4  in  DW  ID PC+4.
- rd, rt  in  RW  destination candidates.
- stall_n  out  1  0 = freeze PC and IF/ID (wpcir).
- ewreg, em2reg, ewmem, ejal, ealuimm  out  1 each  EX controls.
- ealuc  out  5  EX ALU code.
- ern  out  RW  EX destination: 31 if jal, rt if regrt, else rd.
- ea, eb, estore, eimm, epc4  out  DW  EX operands.
- ex_is_uncond, ex_is_cond  out  1 each  EX holds j/jal, or beq/bne.
- evalid  out  1  EX slot holds a real instruction.

Behaviour:
- Reset (resetn=0, asynchronous): every registered output is 0, evalid=0. stall_n is combinational and equals 1 while no hazard is present.
- Latency is 1 cycle. Each rising edge either loads the ID instruction or loads a bubble; the stage never holds its contents.
- Operand selects:
  - ea = mux(a_depen).
  - Forwarded B = mux(b_depen).
  - eb = imm when ealuimm else forwarded B.
  - estore = mux(store_depen), independent of b_depen.
  - Code 11 uses mmo.
- ealuimm = regrt & ~jal, computed at ID and registered.
- Normal edge (load_depen=0, flush=0): all controls and operands are latched, and evalid=1.
- Bubble edge (load_depen=1 or flush=1):
  - ewreg, em2reg, ewmem, ejal, ex_is_uncond, ex_is_cond and evalid are all 0, and ern=0.
  - Data fields are don't-care; implement them as 0.
- stall_n = ~(load_depen & ~flush).
- Simultaneous load_depen and flush: flush wins, stall_n=1, and a bubble is loaded, because the ID instruction is dead.
- A bubble with ern=0 and ewreg=0 must never create a dependency at the control unit.
- A load-use stall lasts exactly one cycle by construction. The block does not count it; the control unit's load_depen drops once em2reg is bubbled.
- resetn asserted mid-stall: all outputs are cleared at once and stall_n returns to 1.

Optional Feature:
- Macro PIPE_STALL_CNT_EN. When defined, adds output ports stall_cnt (32) and flush_cnt (32).
  - stall_cnt increments on each edge with load_depen & ~flush.
  - flush_cnt increments on each edge with flush.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - Forward-select constants FWD_RF=2'b00, FWD_EXE=2'b01, FWD_MEM=2'b10, FWD_MMO=2'b11.
  - REG_RA=5'd31.
  - ALU code width.
- One sub-module, pipe_fwd_mux: 4:1 DW-wide select, instantiated three times (A, B, store).

Test Plan:
- Reset: resetn=0 while inputs toggle -> all outputs 0, evalid=0, stall_n=1. After release, the first normal edge gives evalid=1.
- Store forward from EX: op=sw, store_depen=01, ealu=32'h0000_00AA, qb=32'h1 -> after edge, estore=32'hAA, ewmem=1, eb=imm.
- Store forward from MEM: store_depen=10, malu=32'h55, ealu=32'hAA -> estore=32'h55.
- Load-use: load_depen=1, wreg=1, rd=5'd3 -> stall_n=0 the same cycle. After edge: ewreg=0, ern=0, evalid=0. Next cycle with load_depen=0 and a_depen=11, mmo=32'h1234 -> ea=32'h1234.
- Flush plus load_depen together: flush=1, load_depen=1 -> stall_n=1, a bubble is loaded, and flush_cnt=1 with stall_cnt unchanged (when PIPE_STALL_CNT_EN is defined).
- jal: jal=1, pc4=32'h40 -> ern=31, ewreg=1, ex_is_uncond=1, epc4=32'h40. Following bne with regrt=0 -> ex_is_cond=1, ern=rd.
